ibex_register_file_mp: RTL

//  Parametrised multi-port flip-flop register file (next generation of the FF regfile) for dual-issue/LSU-writeback cores.

---
 rtl/ibex_rf_mp_pkg.sv | 46 ++++
 rtl/ibex_rf_scoreboard.sv | 57 +++++
 rtl/ibex_register_file_mp.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_rf_mp_pkg.sv
// ----------------------------------------------------------------------------
// ibex_rf_mp_pkg
//   Shared types, constants and helpers for the multi-port register file
//   (ibex_register_file_mp) and its pending-write scoreboard
//   (ibex_rf_scoreboard).
//
//   Contents:
//     wipe_state_e  - states of the zeroisation FSM
//     PORT_ADDR_W   - width of every register index on the ports (always 5)
//     ADDR_W_RV32I  - internal index width for the 32-word file
//     ADDR_W_RV32E  - internal index width for the 16-word file
//     MAX_READ      - largest supported number of read ports
//     MAX_WRITE     - largest supported number of write ports
//     addr_width()  - internal index width for a given RV32E setting
//     num_words()   - number of architectural words for a given RV32E setting
//     addr_ok()     - true when a 5-bit port index names a writable word
// ----------------------------------------------------------------------------
package ibex_rf_mp_pkg;

   typedef enum logic [1:0] {
      WIPE_IDLE = 2'd0,
      WIPE_RUN  = 2'd1,
      WIPE_DONE = 2'd2
   } wipe_state_e;

   localparam int unsigned PORT_ADDR_W  = 5;
   localparam int unsigned ADDR_W_RV32I = 5;
   localparam int unsigned ADDR_W_RV32E = 4;
   localparam int unsigned MAX_READ     = 4;
   localparam int unsigned MAX_WRITE    = 3;

   function automatic int unsigned addr_width(input bit rv32e);
      return rv32e ? ADDR_W_RV32E : ADDR_W_RV32I;
   endfunction

   function automatic int unsigned num_words(input bit rv32e);
      return rv32e ? 16 : 32;
   endfunction

   // R0 is never writable; with the reduced file, indices 16..31 do not exist
   // and are dropped rather than aliased onto the lower half.
   function automatic logic addr_ok(input logic [PORT_ADDR_W-1:0] a, input bit rv32e);
      return (a != '0) && (!rv32e || !a[PORT_ADDR_W-1]);
   endfunction

endpackage

// File: rtl/ibex_rf_scoreboard.sv
// ----------------------------------------------------------------------------
// ibex_rf_scoreboard
//   One pending bit per register. A bit is set when ID allocates the register
//   as a destination and cleared when any write port writes it. When both
//   happen in the same cycle the allocation wins, because the allocation
//   belongs to a younger instruction whose result is still outstanding.
//   A wipe clears every bit at once and overrides both.
//
//   Ports:
//     clk_i, rst_ni  clock, asynchronous active-low reset
//     set_i          per-register allocate strobes (bit 0 never set by caller)
//     clr_i          per-register write strobes
//     wipe_clr_i     clear all pending bits
//     raddr_i        read-port indices, port k at [5k+:5]
//     rpend_o        pending bit of each addressed register (combinational)
// ----------------------------------------------------------------------------
module ibex_rf_scoreboard
   import ibex_rf_mp_pkg::*;
#(
   parameter int unsigned NumWords = 32,
   parameter int unsigned AddrW    = 5,
   parameter int unsigned NumRead  = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NumWords-1:0]            set_i,
   input  logic [NumWords-1:0]            clr_i,
   input  logic                           wipe_clr_i,
   input  logic [NumRead*PORT_ADDR_W-1:0] raddr_i,
   output logic [NumRead-1:0]             rpend_o
);

   logic [NumWords-1:0] pend_q;
   logic [NumWords-1:0] pend_d;

   always_comb begin
      pend_d = (pend_q & ~clr_i) | set_i;
      if (wipe_clr_i) begin
         pend_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   for (genvar k = 0; k < NumRead; k++) begin : g_rd
      logic [AddrW-1:0] ra;
      assign ra         = raddr_i[k*PORT_ADDR_W +: AddrW];
      assign rpend_o[k] = (ra != '0) && pend_q[ra];
   end

endmodule

// File: rtl/ibex_register_file_mp.sv
// ----------------------------------------------------------------------------
// ibex_register_file_mp
//   Multi-port flip-flop register file for dual-issue / LSU-writeback cores.
//   NumRead combinational read ports, NumWrite synchronous write ports (the
//   highest-numbered enabled port wins on a collision), a pending-write
//   scoreboard and a hardware wipe FSM that zeroises the whole file.
//   R0 always reads WordZeroVal.
//
//   Optional feature (macro IBEX_RF_MP_BYPASS_EN):
//     defined     - a read of a register being written this cycle (outside a
//                   wipe) returns the winning wdata_i in the same cycle, and
//                   its rpend_o is 0 unless it is also allocated this cycle.
//     not defined - reads return registered contents only.
//
//   Ports:
//     clk_i, rst_ni   clock, asynchronous active-low reset
//     raddr_i         read indices, port k at [5k+:5]
//     rdata_o         read data, port k at [DW*k+:DW] (combinational)
//     rpend_o         pending bit of each addressed register (combinational)
//     waddr_i/wdata_i/we_i   write ports, index m at [5m+:5] / [DW*m+:DW] / [m]
//     alloc_valid_i/alloc_addr_i   mark a destination register pending
//     wipe_req_i      start zeroisation (sampled only while idle)
//     wipe_busy_o     words are being zeroised
//     wipe_done_o     one-cycle pulse after the last word is zeroised
//     err_o           registered one-cycle pulse: two write ports hit the same
//                     register in the previous cycle
//     wipe_state_o    current wipe FSM state, for observation only
//
//   Interface semantics: there is no back-pressure on any port. A write or an
//   allocation takes effect at the rising edge where its strobe is high,
//   unless the wipe FSM is not idle, in which case it is silently dropped.
//   wipe_req_i is a request level sampled in WIPE_IDLE; wipe_busy_o acts as
//   its acknowledgement and stays high until the last word is cleared.
// ----------------------------------------------------------------------------
module ibex_register_file_mp
   import ibex_rf_mp_pkg::*;
#(
   parameter bit                   RV32E       = 1'b0,
   parameter int unsigned          DataWidth   = 32,
   parameter int unsigned          NumRead     = 2,
   parameter int unsigned          NumWrite    = 2,
   parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [NumRead*PORT_ADDR_W-1:0]  raddr_i,
   output logic [NumRead*DataWidth-1:0]    rdata_o,
   output logic [NumRead-1:0]              rpend_o,
   input  logic [NumWrite*PORT_ADDR_W-1:0] waddr_i,
   input  logic [NumWrite*DataWidth-1:0]   wdata_i,
   input  logic [NumWrite-1:0]             we_i,
   input  logic                            alloc_valid_i,
   input  logic [PORT_ADDR_W-1:0]          alloc_addr_i,
   input  logic                            wipe_req_i,
   output logic                            wipe_busy_o,
   output logic                            wipe_done_o,
   output logic                            err_o,
   output wipe_state_e                     wipe_state_o
);

   localparam int unsigned       NUM_WORDS = num_words(RV32E);
   localparam int unsigned       ADDR_W    = addr_width(RV32E);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_WORDS - 1);

   // -------------------------------------------------------------------------
   // Wipe FSM
   // -------------------------------------------------------------------------
   wipe_state_e       state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              idle;

   assign idle = (state_q == WIPE_IDLE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         WIPE_IDLE: begin
            if (wipe_req_i) begin
               state_d = WIPE_RUN;
               // R0 needs no clearing, so the sweep starts at word 1.
               cnt_d   = ADDR_W'(1);
            end
         end
         WIPE_RUN: begin
            if (cnt_q == LAST_IDX) begin
               state_d = WIPE_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WIPE_DONE: begin
            state_d = WIPE_IDLE;
         end
         default: begin
            state_d = WIPE_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= WIPE_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign wipe_busy_o  = (state_q == WIPE_RUN);
   assign wipe_done_o  = (state_q == WIPE_DONE);
   assign wipe_state_o = state_q;

   // -------------------------------------------------------------------------
   // Write decode and priority
   // -------------------------------------------------------------------------
   logic [ADDR_W-1:0]    wa [NumWrite];
   logic [NumWrite-1:0]  wr_valid;
   logic [NUM_WORDS-1:0] wr_hit;
   logic [DataWidth-1:0] wr_data [NUM_WORDS];
   logic                 collide;
   logic                 err_q;

   for (genvar m = 0; m < NumWrite; m++) begin : g_wdec
      assign wa[m]       = waddr_i[m*PORT_ADDR_W +: ADDR_W];
      assign wr_valid[m] = we_i[m] && idle &&
                           addr_ok(waddr_i[m*PORT_ADDR_W +: PORT_ADDR_W], RV32E);
   end

   // Ports are visited in ascending order so a later (higher) port overwrites
   // the selection of an earlier one targeting the same word.
   always_comb begin
      wr_hit = '0;
      for (int w = 0; w < NUM_WORDS; w++) begin
         wr_data[w] = WordZeroVal;
      end
      for (int m = 0; m < NumWrite; m++) begin
         if (wr_valid[m]) begin
            wr_hit[wa[m]]  = 1'b1;
            wr_data[wa[m]] = wdata_i[m*DataWidth +: DataWidth];
         end
      end
   end

   always_comb begin
      collide = 1'b0;
      for (int i = 0; i < NumWrite; i++) begin
         for (int j = i + 1; j < NumWrite; j++) begin
            if (wr_valid[i] && wr_valid[j] && (wa[i] == wa[j])) begin
               collide = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else begin
         err_q <= collide;
      end
   end

   assign err_o = err_q;

   // -------------------------------------------------------------------------
   // Flop array. Word 0 is never enabled; its reads are forced below anyway.
   // -------------------------------------------------------------------------
   logic [DataWidth-1:0] rf_q [NUM_WORDS];

   for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
      logic wipe_we;
      assign wipe_we = (state_q == WIPE_RUN) && (cnt_q == ADDR_W'(w));

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            rf_q[w] <= WordZeroVal;
         end else if (wipe_we) begin
            rf_q[w] <= WordZeroVal;
         end else if (wr_hit[w]) begin
            rf_q[w] <= wr_data[w];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Scoreboard
   // -------------------------------------------------------------------------
   logic                 alloc_ok;
   logic [NUM_WORDS-1:0] alloc_set;
   logic [NumRead-1:0]   rpend_sb;

   assign alloc_ok  = alloc_valid_i && idle && addr_ok(alloc_addr_i, RV32E);
   assign alloc_set = alloc_ok ? (NUM_WORDS'(1) << alloc_addr_i[ADDR_W-1:0]) : '0;

   ibex_rf_scoreboard #(
      .NumWords (NUM_WORDS),
      .AddrW    (ADDR_W),
      .NumRead  (NumRead)
   ) u_scoreboard (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .set_i      (alloc_set),
      .clr_i      (wr_hit),
      .wipe_clr_i (idle && wipe_req_i),
      .raddr_i    (raddr_i),
      .rpend_o    (rpend_sb)
   );

   // -------------------------------------------------------------------------
   // Read ports
   // -------------------------------------------------------------------------
   for (genvar k = 0; k < NumRead; k++) begin : g_read
      logic [ADDR_W-1:0]    ra;
      logic [DataWidth-1:0] rd;
      logic                 pend;

      assign ra = raddr_i[k*PORT_ADDR_W +: ADDR_W];

      always_comb begin
         rd   = (ra == '0) ? WordZeroVal : rf_q[ra];
         pend = rpend_sb[k];
`ifdef IBEX_RF_MP_BYPASS_EN
         // wr_hit is already gated by idle and never set for R0.
         if (wr_hit[ra]) begin
            rd   = wr_data[ra];
            pend = alloc_set[ra];
         end
`endif
      end

      assign rdata_o[k*DataWidth +: DataWidth] = rd;
      assign rpend_o[k]                        = pend;
   end

endmodule
